led_chaser: RTL
===============

// Module: led_chaser
// PURPOSE
//   Parametrised LED pattern engine driving a bank of WIDTH LEDs from a programmable step tick.
//   Step patterns: rotate left, rotate right, bounce, bar-fill. Run/pause and single-step controls.
//   Runtime mode/period configuration through a valid/ready port.
//   Sits between the top-level wrapper (switch inputs) and the uo_out LED pins.
// PARAMETERS
//   WIDTH        8             number of LEDs (>=2); PW = $clog2(WIDTH)
//   DIV_W        24            prescaler width
//   DEFAULT_DIV  24'd10_000_000  step period in clk cycles after reset (1 s at 10 MHz)
//   ACTIVE_LOW   1             1: lit LED drives 0 on led_out; 0: lit LED drives 1
//   PWM_W        4             brightness counter width (used only with LED_CHASER_PWM_EN)
// PORTS
//   clk        in   1        single clock
//   reset      in   1        synchronous, active-high reset
//   en         in   1        1 = run prescaler; 0 = pause (state and prescaler hold)
//   step_now   in   1        1-cycle pulse: force one step, independent of en
//   cfg_valid  in   1        config request
//   cfg_ready  out  1        config accept; transfer when cfg_valid & cfg_ready
//   cfg_mode   in   2        0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 FILL
//   cfg_div    in   DIV_W    step period in cycles; 0 treated as 1
//   pwm_duty   in   PWM_W    brightness (ignored without LED_CHASER_PWM_EN)
//   led_out    out  WIDTH    registered LED drive, polarity per ACTIVE_LOW
//   tick       out  1        registered 1-cycle pulse in the cycle led_out changes due to a step
//   pos        out  PW       current head position
// BEHAVIOUR
//   Reset: state IDLE, mode_reg=ROT_L, div_reg=DEFAULT_DIV, div_cnt=0, pos=0, dir=up, lit=0,
//     led_out = all LEDs off (all 1s if ACTIVE_LOW), tick=0, cfg_ready=1.
//   Prescaler: when en=1, div_cnt increments; at div_cnt==max(div_reg,1)-1 -> step request, div_cnt<=0.
//     en=0: div_cnt holds, no request. Step = request OR step_now (coincident -> one step only).
//   FSM: IDLE (lit=0) -> RUN on step; RUN -> RUN on step; any state -> APPLY on cfg accept;
//     APPLY -> IDLE after exactly 1 cycle. cfg_ready=0 only in APPLY; steps in APPLY are discarded.
//   IDLE->RUN start: pos=WIDTH-1 for ROT_R, else pos=0; dir=up.
//   ROT_L: lit = one-hot(pos); pos+1, WIDTH-1 wraps to 0.
//   ROT_R: lit = one-hot(pos); pos-1, 0 wraps to WIDTH-1.
//   BOUNCE: lit = one-hot(pos); reverse at ends without dwell: ..,W-2,W-1,W-2,..,1,0,1,..
//   FILL: lit = bits [pos:0] set; step from pos=WIDTH-1 returns to IDLE (all off), so period WIDTH+1.
//   Cfg accept: mode_reg/div_reg latched, div_cnt<=0, lit<=0, pos<=0, dir=up; accept wins over
//     a coincident step (step dropped). Accept while en=0 allowed.
//   led_out = ACTIVE_LOW ? ~lit : lit, updated the cycle after the step decision; tick aligned with it.
//   Reset mid-operation: all state to reset values next edge, regardless of cfg/step inputs.
// CONFIGURATION
//   LED_CHASER_PWM_EN defined: free-running PWM_W-bit pwm_cnt; an LED is lit only while
//     pwm_cnt < pwm_duty (duty 0 = dark, 2^PWM_W-1 = (2^PWM_W-1)/2^PWM_W on); gating applied
//     before the led_out register; pwm_cnt resets to 0.
//   Not defined: no PWM counter, pwm_duty ignored, lit LEDs fully on.
// TESTING
//   WIDTH=8, ACTIVE_LOW=1, cfg div=4 mode ROT_L, en=1 -> led_out FF, then FE,FD,FB..7F,FE every 4 cycles with tick.
//   mode BOUNCE div=1 -> pos 0,1..7,6..0,1; led_out 7F then BF (no repeated 7F).
//   mode FILL div=1 -> FE,FC,F8..80,00,FF,FE; pos and tick match each step.
//   cfg_valid coincident with step -> no step, cfg_ready=0 one cycle, led_out=FF, next step 4 cycles later.
//   en=0 with step_now pulse -> exactly one step; cfg_div=0 with en=1 -> step every cycle.
//   PWM_EN, pwm_duty=4, PWM_W=4, ROT_L held via en=0 -> lit bit low 4 of every 16 cycles.

Source files
------------

// File: rtl/led_chaser.sv
// ---------------------------------------------------------------------------
// led_chaser
//   LED pattern engine for a bank of WIDTH LEDs. A prescaler produces a step
//   request every max(div,1) enabled cycles; each step advances the head
//   position according to the selected mode (rotate left, rotate right,
//   bounce, bar-fill). Mode and period are reprogrammed through a
//   valid/ready config port; an accepted config clears the display and
//   takes one cycle (APPLY) during which further config and steps are
//   refused.
//
// Optional feature: define LED_CHASER_PWM_EN to add a free-running PWM_W-bit
//   brightness counter; lit LEDs are then only driven while pwm_cnt < pwm_duty.
//   Without it pwm_duty is ignored and lit LEDs are fully on.
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset
//   en         1 = prescaler runs, 0 = prescaler and pattern hold
//   step_now   single-cycle forced step (works with en=0)
//   cfg_valid  config request
//   cfg_ready  config accept (low only in APPLY)
//   cfg_mode   0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 FILL
//   cfg_div    step period in clk cycles, 0 behaves as 1
//   pwm_duty   brightness (PWM build only)
//   led_out    registered LED drive, polarity set by ACTIVE_LOW
//   tick       registered pulse in the cycle led_out changes due to a step
//   pos        current head position
// ---------------------------------------------------------------------------
module led_chaser #(
    parameter int              WIDTH       = 8,
    parameter int              DIV_W       = 24,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(10_000_000),
    parameter bit              ACTIVE_LOW  = 1'b1,
    parameter int              PWM_W       = 4,
    localparam int             PW          = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             step_now,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [PWM_W-1:0] pwm_duty,
    output logic [WIDTH-1:0] led_out,
    output logic             tick,
    output logic [PW-1:0]    pos
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_APPLY} state_e;
    typedef enum logic [1:0] {M_ROTL, M_ROTR, M_BOUNCE, M_FILL} mode_e;

    localparam logic [PW-1:0]    LAST    = PW'(WIDTH - 1);
    // XOR mask that converts the logical lit vector into pin polarity
    localparam logic [WIDTH-1:0] POL     = {WIDTH{ACTIVE_LOW}};

    state_e           state_q,   state_d;
    mode_e            mode_q,    mode_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [PW-1:0]    pos_q,     pos_d;
    logic             dir_q,     dir_d;      // 1 = counting up
    logic [WIDTH-1:0] lit_q,     lit_d;
    logic [WIDTH-1:0] led_out_q, led_out_d;
    logic             tick_q,    tick_d;
    logic             ready_q,   ready_d;

    logic [DIV_W-1:0] div_eff;
    logic             req, accept, step, fill_done;
    logic             pwm_on;

    // Lit vector for a head position: single LED, or bar [p:0] in FILL.
    function automatic logic [WIDTH-1:0] pattern(input mode_e m, input logic [PW-1:0] p);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH; i++)
            v[i] = (m == M_FILL) ? (i <= int'(p)) : (i == int'(p));
        return v;
    endfunction

`ifdef LED_CHASER_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) pwm_cnt_q <= '0;
        else       pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end

    assign pwm_on = (pwm_cnt_q < pwm_duty);
`else
    logic unused_pwm;
    assign unused_pwm = ^pwm_duty;
    assign pwm_on     = 1'b1;
`endif

    always_comb begin
        div_eff   = (div_q == '0) ? DIV_W'(1) : div_q;
        req       = en && (div_cnt_q == div_eff - 1'b1);
        accept    = cfg_valid && ready_q;
        // Config accept wins over a coincident step; APPLY swallows steps.
        step      = (req || step_now) && !accept && (state_q != S_APPLY);

        state_d   = state_q;
        mode_d    = mode_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        lit_d     = lit_q;
        fill_done = 1'b0;

        if (en) div_cnt_d = req ? '0 : div_cnt_q + 1'b1;

        if (accept) begin
            state_d   = S_APPLY;
            mode_d    = mode_e'(cfg_mode);
            div_d     = cfg_div;
            div_cnt_d = '0;
            pos_d     = '0;
            dir_d     = 1'b1;
            lit_d     = '0;
        end else if (state_q == S_APPLY) begin
            state_d = S_IDLE;
        end else if (step) begin
            if (state_q == S_IDLE) begin
                state_d = S_RUN;
                dir_d   = 1'b1;
                pos_d   = (mode_q == M_ROTR) ? LAST : '0;
            end else begin
                case (mode_q)
                    M_ROTL: pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                    M_ROTR: pos_d = (pos_q == '0) ? LAST : pos_q - 1'b1;
                    M_BOUNCE: begin
                        // Turn around at either end without repeating the end LED
                        if (dir_q) begin
                            if (pos_q == LAST) begin
                                pos_d = pos_q - 1'b1;
                                dir_d = 1'b0;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                pos_d = PW'(1);
                                dir_d = 1'b1;
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                    default: begin // M_FILL: full bar steps back to a dark IDLE
                        if (pos_q == LAST) begin
                            state_d   = S_IDLE;
                            pos_d     = '0;
                            fill_done = 1'b1;
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end
                endcase
            end
            lit_d = fill_done ? '0 : pattern(mode_q, pos_d);
        end

        // led_out is built from the next lit value so display, pos and tick
        // all change on the same edge.
        led_out_d = (lit_d & {WIDTH{pwm_on}}) ^ POL;
        tick_d    = step;
        ready_d   = (state_d != S_APPLY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= M_ROTL;
            div_q     <= DEFAULT_DIV;
            div_cnt_q <= '0;
            pos_q     <= '0;
            dir_q     <= 1'b1;
            lit_q     <= '0;
            led_out_q <= POL;
            tick_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            lit_q     <= lit_d;
            led_out_q <= led_out_d;
            tick_q    <= tick_d;
            ready_q   <= ready_d;
        end
    end

    assign led_out   = led_out_q;
    assign tick      = tick_q;
    assign pos       = pos_q;
    assign cfg_ready = ready_q;

endmodule
